lcd_writer: RTL
===============

# lcd_writer

Character-LCD (HD44780-compatible, 8-bit bus, write-only) controller that sits behind the calculator control unit. It runs the controller's power-up initialisation by itself, then accepts command/character bytes over a valid/ready handshake. Each accepted byte is driven onto the LCD bus with correctly timed setup, enable pulse and execution wait. It is the receiving end of the byte stream the control unit produces for the LCD.

## Interface
- `PWRUP_CYC`, default 750000: wait after reset before the first init write (15 ms at 50 MHz).
- `SETUP_CYC`, default 2: cycles RS/DATA are stable with EN low before the EN pulse.
- `EN_HIGH_CYC`, default 12: LCD_EN high width in cycles.
- `CMD_WAIT_CYC`, default 2000: wait after EN falls for a normal byte (40 µs).
- `CLEAR_WAIT_CYC`, default 82000: wait after EN falls for a command of 0x01, 0x02 or 0x03 (1.64 ms).
- `clk  in  1`: CLOCK_50 domain; all logic on the rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `in_valid  in  1`: byte offered.
- `in_rs  in  1`: 0 = command, 1 = character data.
- `in_data  in  8`: byte to write.
- `in_ready  out  1`: block accepts the byte this cycle.
- `init_done  out  1`: init sequence complete; stays high until reset.
- `LCD_DATA  out  8`: LCD data bus.
- `LCD_RS  out  1`: register select.
- `LCD_RW  out  1`: constant 0 (write only).
- `LCD_EN  out  1`: enable strobe.

## Operation
- States: PWR_WAIT → INIT → SETUP → EN_HIGH → HOLD_WAIT → (INIT | IDLE); IDLE → SETUP on accept.
- PWR_WAIT: count PWRUP_CYC cycles, then go to INIT.
- INIT: issues the init ROM commands 0x38, 0x38, 0x0C, 0x01, 0x06 (RS=0) in order, each through SETUP/EN_HIGH/HOLD_WAIT. After the fifth command, set init_done and go to IDLE.
- IDLE: `in_ready=1`. A transfer happens when `in_valid && in_ready` at a rising edge. in_rs and in_data are captured and the block goes to SETUP.
- SETUP: drive LCD_RS/LCD_DATA from the captured byte with LCD_EN=0 for SETUP_CYC cycles.
- EN_HIGH: LCD_EN=1 for EN_HIGH_CYC cycles; RS/DATA unchanged.
- HOLD_WAIT: LCD_EN=0; RS/DATA held. Wait CLEAR_WAIT_CYC if RS=0 and data ∈ {0x01,0x02,0x03}, otherwise CMD_WAIT_CYC.
- in_ready is 0 in every state except IDLE. A valid byte held during the busy period is accepted on the first IDLE cycle.
- Counters are sized to hold the largest parameter. A zero-length phase parameter is treated as 1.

## Timing
- Reset values: LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, in_ready=0, init_done=0. State is PWR_WAIT and counters are 0.
- If reset is asserted mid-transfer, LCD_EN is low on the next clock and the whole power-up/init sequence restarts.
- Accept at edge T: LCD_RS/LCD_DATA are valid at T+1.
- LCD_EN is high from T+1+SETUP_CYC for EN_HIGH_CYC cycles.
- in_ready returns high at T+1+SETUP_CYC+EN_HIGH_CYC+WAIT, where WAIT is CMD_WAIT_CYC or CLEAR_WAIT_CYC.
- Back-to-back: with in_valid held high, the next accept happens on the first cycle in_ready is high; there are no extra idle cycles.
- init_done rises in the same cycle in_ready first rises.

## Configuration
- `LCD_WRITER_AUTOWRAP_EN` defined:
  - A 6-bit column counter (0..32) tracks the 16x2 display position. It resets to 0 on rst_n and on command 0x01/0x02.
  - An accepted command with bit7=1 sets column = (data[6] ? 16 : 0) + data[3:0].
  - Each character write increments the column.
  - Before writing a character when column==16, the block inserts command 0xC0 (full SETUP/EN/WAIT cycle), then writes the character; column becomes 17.
  - When column==32, it inserts 0x80 and sets column to 0, then writes the character; column becomes 1.
  - in_ready stays low during the inserted command.
- Not defined: no column tracking; bytes pass through unchanged.

## Test plan
Test parameters: PWRUP_CYC=100, SETUP_CYC=2, EN_HIGH_CYC=4, CMD_WAIT_CYC=20, CLEAR_WAIT_CYC=50.
- Reset release, no input → five EN pulses with DATA 0x38, 0x38, 0x0C, 0x01, 0x06 and RS=0; first EN rise at cycle 103 after reset release; 0x01 is followed by a 50-cycle wait; init_done and in_ready go high together.
- After init, accept rs=1/0x41 at T → DATA=0x41 and RS=1 at T+1; EN high T+3..T+6; in_ready high at T+27.
- Command 0x01 accepted at T → in_ready returns at T+57; command 0x80 → in_ready returns at T+27.
- in_valid held high with three bytes presented back-to-back → exactly three EN pulses, each byte accepted once, in order, with no byte dropped or repeated.
- rst_n low during EN_HIGH → LCD_EN=0 and all outputs at reset values the next cycle; the init sequence repeats from PWR_WAIT.
- With AUTOWRAP_EN defined, 17 characters 'A'..'Q' → 0xC0 command pulse between 'P' and 'Q'. With 33 characters → 0x80 inserted before the 33rd. Without the macro, no inserted pulses.

Source files
------------

// File: rtl/lcd_writer.sv
// HD44780-style 8-bit write-only LCD driver: self-runs power-up init, then writes handshaked bytes.
// Latency: byte on bus one cycle after accept; EN pulse after SETUP_CYC; ready again after the execution wait.
// Backpressure: in_ready is high only in IDLE; a held in_valid is taken on the first IDLE cycle.
//
// Ports: clk/rst_n (synchronous active-low reset); in_valid/in_rs/in_data/in_ready byte handshake;
// init_done sticky after the init sequence; LCD_DATA/LCD_RS/LCD_RW/LCD_EN drive the panel.
// Optional macro LCD_WRITER_AUTOWRAP_EN: track the 16x2 cursor column and insert line-change commands.
module lcd_writer #(
    parameter int PWRUP_CYC      = 750000,
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 12,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       init_done,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN
);

    // Zero-length phases are stretched to one cycle so every state is visited.
    localparam int PWR_N = (PWRUP_CYC      < 1) ? 1 : PWRUP_CYC;
    localparam int SET_N = (SETUP_CYC      < 1) ? 1 : SETUP_CYC;
    localparam int ENH_N = (EN_HIGH_CYC    < 1) ? 1 : EN_HIGH_CYC;
    localparam int CMD_N = (CMD_WAIT_CYC   < 1) ? 1 : CMD_WAIT_CYC;
    localparam int CLR_N = (CLEAR_WAIT_CYC < 1) ? 1 : CLEAR_WAIT_CYC;

    localparam int MAX_A = (PWR_N > SET_N) ? PWR_N : SET_N;
    localparam int MAX_B = (ENH_N > CMD_N) ? ENH_N : CMD_N;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_N = (MAX_C > CLR_N) ? MAX_C : CLR_N;
    localparam int CNT_W = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_N - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SET_N - 1);
    localparam logic [CNT_W-1:0] ENH_LAST = CNT_W'(ENH_N - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_N - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_N - 1);

    localparam logic [2:0] S_PWR_WAIT  = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_EN_HIGH   = 3'd3;
    localparam logic [2:0] S_HOLD_WAIT = 3'd4;
    localparam logic [2:0] S_IDLE      = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       init_idx;
    logic             slow_cmd;
    logic [CNT_W-1:0] hold_last;

`ifdef LCD_WRITER_AUTOWRAP_EN
    logic [5:0] col;
    logic       pend_vld;   // a character is parked behind an inserted line-change command
    logic [7:0] pend_dat;
`endif

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = 8'h38;
            3'd1:    init_rom = 8'h38;
            3'd2:    init_rom = 8'h0C;
            3'd3:    init_rom = 8'h01;
            default: init_rom = 8'h06;
        endcase
    endfunction

    // Clear / return-home commands need the long execution wait; the bus regs hold the byte in flight.
    assign slow_cmd  = !LCD_RS && (LCD_DATA == 8'h01 || LCD_DATA == 8'h02 || LCD_DATA == 8'h03);
    assign hold_last = slow_cmd ? CLR_LAST : CMD_LAST;
    assign in_ready  = (state == S_IDLE);
    assign LCD_RW    = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_PWR_WAIT;
            cnt       <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            LCD_DATA  <= 8'h00;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
`ifdef LCD_WRITER_AUTOWRAP_EN
            col       <= '0;
            pend_vld  <= 1'b0;
            pend_dat  <= 8'h00;
`endif
        end else begin
            case (state)
                S_PWR_WAIT: begin
                    if (cnt == PWR_LAST) begin
                        cnt   <= '0;
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_INIT: begin
                    LCD_DATA <= init_rom(init_idx);
                    LCD_RS   <= 1'b0;
                    cnt      <= '0;
                    state    <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt == SET_LAST) begin
                        cnt    <= '0;
                        LCD_EN <= 1'b1;
                        state  <= S_EN_HIGH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_EN_HIGH: begin
                    if (cnt == ENH_LAST) begin
                        cnt    <= '0;
                        LCD_EN <= 1'b0;
                        state  <= S_HOLD_WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HOLD_WAIT: begin
                    if (cnt == hold_last) begin
                        cnt <= '0;
                        if (!init_done) begin
                            if (init_idx == 3'd4) begin
                                init_done <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                init_idx <= init_idx + 3'd1;
                                state    <= S_INIT;
                            end
                        end
`ifdef LCD_WRITER_AUTOWRAP_EN
                        else if (pend_vld) begin
                            // Line change done; write the parked character without visiting IDLE.
                            LCD_DATA <= pend_dat;
                            LCD_RS   <= 1'b1;
                            pend_vld <= 1'b0;
                            state    <= S_SETUP;
                        end
`endif
                        else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        cnt   <= '0;
                        state <= S_SETUP;
`ifdef LCD_WRITER_AUTOWRAP_EN
                        if (in_rs && (col == 6'd16 || col == 6'd32)) begin
                            // End of a line: move the cursor first, the character follows.
                            LCD_DATA <= (col == 6'd16) ? 8'hC0 : 8'h80;
                            LCD_RS   <= 1'b0;
                            pend_vld <= 1'b1;
                            pend_dat <= in_data;
                            col      <= (col == 6'd16) ? 6'd17 : 6'd1;
                        end else begin
                            LCD_DATA <= in_data;
                            LCD_RS   <= in_rs;
                            if (in_rs)
                                col <= col + 6'd1;
                            else if (in_data == 8'h01 || in_data == 8'h02)
                                col <= '0;
                            else if (in_data[7])
                                col <= {1'b0, in_data[6], in_data[3:0]};
                        end
`else
                        LCD_DATA <= in_data;
                        LCD_RS   <= in_rs;
`endif
                    end
                end
                default: state <= S_PWR_WAIT;
            endcase
        end
    end

endmodule
